axi_m_uart_bridge: RTL and testbench

AXI4-Lite master that sits upstream of the UART peripheral and drives its slave port.
- TX path: accepts bytes on a valid/ready stream and writes each one to the TX data register.
- RX path: polls the RX data register at a fixed interval and emits each byte received on a valid/ready output stream.
- Lets a streaming core (packet engine, loopback tester) use the UART without a CPU.

---
 rtl/axi_lite_pkg.sv | 22 ++
 rtl/axi_m_uart_bridge.sv | 160 ++++++++++++++++
 tb/tb_axi_m_uart_bridge.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// AXI4-Lite response encodings and the bridge FSM state type.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RX_HOLD = 3'd5
    } state_e;

    // SLVERR and DECERR both mean the slave refused the access.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axi_m_uart_bridge.sv
// AXI4-Lite master that pushes stream bytes into the UART TX data register
// and polls the UART RX data register, forwarding received bytes as a stream.
module axi_m_uart_bridge
    import axi_lite_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH  = 32,
    parameter logic [31:0] TX_ADDR       = 32'h0000_0000,
    parameter logic [31:0] RX_ADDR       = 32'h0000_0004,
    parameter int unsigned POLL_INTERVAL = 64,
    parameter int unsigned ERR_CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [7:0]                s_tx_data,
    input  logic                      s_tx_valid,
    output logic                      s_tx_ready,
    output logic [7:0]                m_rx_data,
    output logic                      m_rx_valid,
    input  logic                      m_rx_ready,
    output logic [31:0]               awaddr,
    output logic [3:0]                awprot,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [C_DATA_WIDTH-1:0]   wdata,
    output logic [C_DATA_WIDTH/8-1:0] wstrb,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic [1:0]                bresp,
    input  logic                      bvalid,
    output logic                      bready,
    output logic [31:0]               araddr,
    output logic [3:0]                arprot,
    output logic                      arvalid,
    input  logic                      arready,
    input  logic [C_DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]                rresp,
    input  logic                      rvalid,
    output logic                      rready,
    output logic [ERR_CNT_W-1:0]      wr_err_cnt,
    output logic [ERR_CNT_W-1:0]      rd_err_cnt
);

    localparam int unsigned TMR_W  = $clog2(POLL_INTERVAL + 1);
    localparam int unsigned STRB_W = C_DATA_WIDTH / 8;

    state_e                  state_q, state_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic                    rr_tx_q;
    logic                    aw_pend_q, w_pend_q;
    logic [31:0]             awaddr_q, araddr_q;
    logic [C_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]       wstrb_q;
    logic [7:0]              rx_byte_q;
    logic [ERR_CNT_W-1:0]    wr_err_q, rd_err_q;

    logic poll_req, tx_grant, rd_grant, wr_done, wr_resp, wr_retry;
    logic rd_done, rd_ok, rd_dec;
    logic unused_rdata;

    // Only the low byte of a read carries UART data.
    assign unused_rdata = ^rdata[C_DATA_WIDTH-1:8];

    // Arbitration: a due poll and a waiting byte are resolved by the round-robin flag.
    assign poll_req = (tmr_q == '0);
    assign tx_grant = nrst && (state_q == ST_IDLE) && s_tx_valid && (!poll_req || rr_tx_q);
    assign rd_grant = (state_q == ST_IDLE) && poll_req && !tx_grant;

    assign wr_done  = (state_q == ST_WR) && (!aw_pend_q || awready) && (!w_pend_q || wready);
    assign wr_resp  = (state_q == ST_WR_RESP) && bvalid;
    assign wr_retry = wr_resp && resp_is_err(bresp);
    assign rd_done  = (state_q == ST_RD_DATA) && rvalid;
    assign rd_ok    = rd_done && !resp_is_err(rresp);
    assign rd_dec   = rd_done && (rresp == RESP_DECERR);

    assign s_tx_ready = tx_grant;
    assign awaddr     = awaddr_q;
    assign awprot     = 4'b0000;
    assign awvalid    = aw_pend_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign wvalid     = w_pend_q;
    assign bready     = (state_q == ST_WR_RESP);
    assign araddr     = araddr_q;
    assign arprot     = 4'b0000;
    assign arvalid    = (state_q == ST_RD_ADDR);
    assign rready     = (state_q == ST_RD_DATA);
    assign m_rx_valid = (state_q == ST_RX_HOLD);
    assign m_rx_data  = rx_byte_q;
    assign wr_err_cnt = wr_err_q;
    assign rd_err_cnt = rd_err_q;

    // Next-state logic for the transaction sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_grant)      state_d = ST_WR;
                else if (rd_grant) state_d = ST_RD_ADDR;
            end
            ST_WR:      if (wr_done) state_d = ST_WR_RESP;
            ST_WR_RESP: if (wr_resp) state_d = wr_retry ? ST_WR : ST_IDLE;
            ST_RD_ADDR: if (arready) state_d = ST_RD_DATA;
            ST_RD_DATA: if (rd_done) state_d = rd_ok ? ST_RX_HOLD : ST_IDLE;
            ST_RX_HOLD: if (m_rx_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Poll timer: reloads when a read finishes, frozen while a read is in progress, parks at 0.
    always_comb begin
        tmr_d = tmr_q;
        if (rd_done) begin
            tmr_d = TMR_W'(POLL_INTERVAL);
        end else if ((state_q == ST_IDLE || state_q == ST_WR || state_q == ST_WR_RESP)
                     && (tmr_q != '0)) begin
            tmr_d = tmr_q - 1'b1;
        end
    end

    // State, channel valids, latched payloads and saturating error counters.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            tmr_q     <= TMR_W'(POLL_INTERVAL);
            rr_tx_q   <= 1'b1;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rx_byte_q <= '0;
            wr_err_q  <= '0;
            rd_err_q  <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            if (tx_grant) rr_tx_q <= 1'b0;
            if (rd_grant) rr_tx_q <= 1'b1;
            // A retry re-issues both channels with the byte already held in wdata_q.
            if (tx_grant || wr_retry) begin
                aw_pend_q <= 1'b1;
                w_pend_q  <= 1'b1;
            end else begin
                if (awready) aw_pend_q <= 1'b0;
                if (wready)  w_pend_q  <= 1'b0;
            end
            if (tx_grant) begin
                awaddr_q <= TX_ADDR;
                wdata_q  <= {{(C_DATA_WIDTH-8){1'b0}}, s_tx_data};
                wstrb_q  <= STRB_W'(1);
            end
            if (rd_grant) araddr_q <= RX_ADDR;
            if (rd_ok) rx_byte_q <= rdata[7:0];
            if (wr_retry && (wr_err_q != '1)) wr_err_q <= wr_err_q + 1'b1;
            if (rd_dec && (rd_err_q != '1)) rd_err_q <= rd_err_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_m_uart_bridge.sv
// Directed-plus-random bench for axi_m_uart_bridge with an AXI4-Lite slave model.
module tb_axi_m_uart_bridge;
    import axi_lite_pkg::*;

    localparam int          DW  = 32;
    localparam logic [31:0] TXA = 32'h0000_0010;
    localparam logic [31:0] RXA = 32'h0000_0014;
    localparam int          PI  = 4;
    localparam int          EW  = 3;
    localparam int          SAT = (1 << EW) - 1;

    logic clk, nrst;
    logic [7:0] s_tx_data, m_rx_data;
    logic s_tx_valid, s_tx_ready, m_rx_valid, m_rx_ready;
    logic [31:0] awaddr, araddr;
    logic [3:0] awprot, arprot, wstrb;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [1:0] bresp, rresp;
    logic [EW-1:0] wr_err_cnt, rd_err_cnt;

    axi_m_uart_bridge #(
        .C_DATA_WIDTH(DW), .TX_ADDR(TXA), .RX_ADDR(RXA),
        .POLL_INTERVAL(PI), .ERR_CNT_W(EW)
    ) dut (
        .clk(clk), .nrst(nrst),
        .s_tx_data(s_tx_data), .s_tx_valid(s_tx_valid), .s_tx_ready(s_tx_ready),
        .m_rx_data(m_rx_data), .m_rx_valid(m_rx_valid), .m_rx_ready(m_rx_ready),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .wr_err_cnt(wr_err_cnt), .rd_err_cnt(rd_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave behaviour plan, written by the stimulus block.
    int aw_dly, w_dly, ar_dly;
    logic [1:0] bplan [0:255];
    logic [1:0] rplan [0:4095];
    logic [7:0] rbyte [0:4095];

    // Slave state and transaction logs.
    int aw_wait, w_wait, ar_wait;
    bit aw_seen, w_seen;
    int aw_n = 0, w_n = 0, b_n = 0, b_idx = 0, r_idx = 0, rx_n = 0, viol = 0;
    int aw_last, w_last;
    logic [31:0] aw_log [0:255];
    logic [31:0] w_log [0:255];
    logic [3:0]  s_log [0:255];
    logic [7:0]  rx_log [0:255];
    bit pav, pwv, parv, pmv;
    logic [31:0] paw, par, pwd;
    logic [3:0] pws;
    logic [7:0] pmd;

    assign awready = awvalid && (aw_wait >= aw_dly);
    assign wready  = wvalid && (w_wait >= w_dly);
    assign arready = arvalid && (ar_wait >= ar_dly);

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
            aw_seen <= 1'b0; w_seen <= 1'b0;
            bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
            pav <= 1'b0; pwv <= 1'b0; parv <= 1'b0; pmv <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                aw_log[aw_n] <= awaddr; aw_n <= aw_n + 1;
                aw_seen <= 1'b1; aw_last <= aw_wait + 1; aw_wait <= 0;
            end else if (awvalid) aw_wait <= aw_wait + 1;
            if (wvalid && wready) begin
                w_log[w_n] <= wdata; s_log[w_n] <= wstrb; w_n <= w_n + 1;
                w_seen <= 1'b1; w_last <= w_wait + 1; w_wait <= 0;
            end else if (wvalid) w_wait <= w_wait + 1;
            if (bvalid && bready) begin
                bvalid <= 1'b0; b_n <= b_n + 1;
            end else if (!bvalid && aw_seen && w_seen) begin
                bvalid <= 1'b1; bresp <= bplan[b_idx]; b_idx <= b_idx + 1;
                aw_seen <= 1'b0; w_seen <= 1'b0;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                rvalid <= 1'b1; rresp <= rplan[r_idx];
                rdata <= {24'($urandom), rbyte[r_idx]};
                r_idx <= r_idx + 1; ar_wait <= 0;
            end else if (arvalid) ar_wait <= ar_wait + 1;
            if (m_rx_valid && m_rx_ready) begin
                rx_log[rx_n] <= m_rx_data; rx_n <= rx_n + 1;
            end
            // Protocol watch: payload stability while waiting, single outstanding transaction.
            if (pav && !(awvalid && awaddr == paw)) viol <= viol + 1;
            if (pwv && !(wvalid && wdata == pwd && wstrb == pws)) viol <= viol + 1;
            if (parv && !(arvalid && araddr == par)) viol <= viol + 1;
            if (pmv && !(m_rx_valid && m_rx_data == pmd)) viol <= viol + 1;
            if ((awvalid || wvalid || bready) && (arvalid || rready)) viol <= viol + 1;
            pav <= awvalid && !awready; paw <= awaddr;
            pwv <= wvalid && !wready; pwd <= wdata; pws <= wstrb;
            parv <= arvalid && !arready; par <= araddr;
            pmv <= m_rx_valid && !m_rx_ready; pmd <= m_rx_data;
        end
    end

    int tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    // Offer one byte; returns the number of completed write responses seen at acceptance.
    task automatic send_byte(input logic [7:0] b, output int acc_bn);
        bit got = 0;
        s_tx_data = b; s_tx_valid = 1'b1; acc_bn = -1;
        for (int k = 0; k < 400 && !got; k++) begin
            #1;
            if (s_tx_ready) got = 1; else @(negedge clk);
        end
        if (!got) chk("tx_accept_timeout", 64'(s_tx_ready), 64'd1);
        else begin
            acc_bn = b_n;
            @(posedge clk); #1;
            chk("tx_latency", {62'd0, awvalid, wvalid}, 64'd3);
        end
        @(negedge clk); s_tx_valid = 1'b0;
    endtask

    task automatic wait_bn(input int target);
        for (int k = 0; k < 600 && b_n < target; k++) @(negedge clk);
        chk("wait_bresp", 64'(b_n >= target), 64'd1);
    endtask

    task automatic wait_ridx(input int target);
        for (int k = 0; k < 1500 && r_idx < target; k++) begin
            @(negedge clk); m_rx_ready = 1'($urandom_range(0, 1));
        end
        chk("wait_reads", 64'(r_idx >= target), 64'd1);
        m_rx_ready = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int n, bn0, wn0, rn, rx0, ar0, acc, wr_tot, rd_tot;
        logic [7:0] x, y;
        logic [7:0] exp_w[$];
        logic [7:0] exp_rx[$];

        for (int i = 0; i < 256; i++) bplan[i] = RESP_OKAY;
        for (int i = 0; i < 4096; i++) begin rplan[i] = RESP_SLVERR; rbyte[i] = 8'h00; end
        aw_dly = 0; w_dly = 0; ar_dly = 0;
        wr_tot = 0; rd_tot = 0;
        nrst = 1'b0; s_tx_valid = 1'b1; s_tx_data = 8'hFF; m_rx_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_handshakes", {57'd0, awvalid, wvalid, arvalid, bready, rready, m_rx_valid, s_tx_ready}, 64'd0);
        chk("rst_addr", {awaddr, araddr}, 64'd0);
        chk("rst_wdata", {28'd0, wdata, wstrb}, 64'd0);
        chk("rst_cnt", 64'({wr_err_cnt, rd_err_cnt}), 64'd0);
        chk("prot", 64'({awprot, arprot}), 64'd0);
        s_tx_valid = 1'b0;
        @(negedge clk); nrst = 1'b1;

        // First poll comes POLL_INTERVAL decrements after reset plus one grant cycle
        n = 0;
        while (!arvalid && n < 50) begin @(negedge clk); n++; end
        chk("first_poll_delay", 64'(n), 64'(PI + 1));
        chk("araddr", 64'(araddr), 64'(RXA));

        // TX single byte with a zero-wait slave
        repeat (4) @(negedge clk);
        bn0 = b_n; wn0 = w_n;
        send_byte(8'hA5, acc);
        wait_bn(bn0 + 1);
        repeat (10) @(negedge clk);
        chk("tx1_awaddr", 64'(aw_log[aw_n-1]), 64'(TXA));
        chk("tx1_wdata", 64'(w_log[wn0]), 64'h0000_00A5);
        chk("tx1_wstrb", 64'(s_log[wn0]), 64'd1);
        chk("tx1_count", 64'(w_n - wn0), 64'd1);

        // AW delayed three cycles, W immediate
        aw_dly = 3; bn0 = b_n;
        send_byte(8'($urandom), acc);
        wait_bn(bn0 + 1);
        repeat (6) @(negedge clk);
        chk("skew_aw_cycles", 64'(aw_last), 64'd4);
        chk("skew_w_cycles", 64'(w_last), 64'd1);
        chk("skew_bresp_count", 64'(b_n - bn0), 64'd1);
        aw_dly = 0;

        // Write refused once, then accepted; next byte waits for the OKAY
        bn0 = b_n; wn0 = w_n;
        bplan[b_idx] = RESP_SLVERR; bplan[b_idx + 1] = RESP_OKAY;
        wr_tot++;
        x = 8'($urandom);
        send_byte(8'h3C, acc);
        send_byte(x, acc);
        chk("bp_accept_after_okay", 64'(acc), 64'(bn0 + 2));
        wait_bn(bn0 + 3);
        chk("bp_retry_data0", 64'(w_log[wn0]), 64'h3C);
        chk("bp_retry_data1", 64'(w_log[wn0 + 1]), 64'h3C);
        chk("bp_next_data", 64'(w_log[wn0 + 2]), 64'(x));
        chk("bp_wr_err", 64'(wr_err_cnt), 64'(sat(wr_tot)));

        // RX: two empty polls, then a byte held against a stalled consumer
        @(negedge clk);
        m_rx_ready = 1'b0; rn = r_idx; rx0 = rx_n;
        rplan[rn] = RESP_SLVERR; rplan[rn + 1] = RESP_SLVERR;
        rplan[rn + 2] = RESP_OKAY; rbyte[rn + 2] = 8'h42;
        n = 0;
        while (!m_rx_valid && n < 200) begin @(negedge clk); n++; end
        chk("rx_valid_seen", 64'(m_rx_valid), 64'd1);
        chk("rx_empty_no_output", 64'(rx_n - rx0), 64'd0);
        chk("rx_polls_used", 64'(r_idx - rn), 64'd3);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rx_hold", {54'd0, m_rx_valid, arvalid, m_rx_data}, {54'd0, 1'b1, 1'b0, 8'h42});
        end
        m_rx_ready = 1'b1;
        @(negedge clk);
        chk("rx_delivered", 64'(rx_n - rx0), 64'd1);
        chk("rx_byte", 64'(rx_log[rx0]), 64'h42);
        chk("rx_valid_drop", 64'(m_rx_valid), 64'd0);

        // Random RX responses with a randomly stalling consumer
        rn = r_idx; rx0 = rx_n; exp_rx.delete();
        for (int j = 0; j < 10; j++) begin
            n = $urandom_range(0, 2);
            rbyte[rn + j] = 8'($urandom);
            rplan[rn + j] = (n == 0) ? RESP_OKAY : (n == 1) ? RESP_SLVERR : RESP_DECERR;
            if (n == 0) exp_rx.push_back(rbyte[rn + j]);
            if (n == 2) rd_tot++;
        end
        wait_ridx(rn + 10);
        chk("rxr_count", 64'(rx_n - rx0), 64'(exp_rx.size()));
        for (int j = 0; j < exp_rx.size(); j++) chk("rxr_byte", 64'(rx_log[rx0 + j]), 64'(exp_rx[j]));
        chk("rxr_rd_err", 64'(rd_err_cnt), 64'(sat(rd_tot)));

        // Continuous TX stream against a short poll interval
        bn0 = b_n; wn0 = w_n; ar0 = r_idx; exp_w.delete();
        n = b_idx;
        for (int j = 0; j < 12; j++) begin
            x = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                bplan[n] = RESP_DECERR; n++; wr_tot++; exp_w.push_back(x);
            end
            bplan[n] = RESP_OKAY; n++;
            exp_w.push_back(x);
        end
        for (int j = 0; j < exp_w.size(); j++) begin
            if (j == 0 || exp_w[j] != exp_w[j - 1] || bplan[b_idx + j - 1] == RESP_OKAY) begin
                aw_dly = $urandom_range(0, 2); w_dly = $urandom_range(0, 2);
                if (j == 0 || bplan[bn0 - b_n + b_idx + j - 1] == RESP_OKAY || 1) begin end
            end
        end
        aw_dly = 0; w_dly = 0;
        for (int j = 0; j < exp_w.size(); j++) begin
            if (j > 0 && bplan[(bn0 - bn0) + n - exp_w.size() + j - 1] != RESP_OKAY) continue;
            aw_dly = $urandom_range(0, 2); w_dly = $urandom_range(0, 2);
            send_byte(exp_w[j], acc);
        end
        wait_bn(bn0 + exp_w.size());
        repeat (10) @(negedge clk);
        chk("arb_write_count", 64'(w_n - wn0), 64'(exp_w.size()));
        for (int j = 0; j < exp_w.size(); j++) chk("arb_wdata", 64'(w_log[wn0 + j]), 64'(exp_w[j]));
        chk("arb_reads_interleaved", 64'(r_idx - ar0 >= 3), 64'd1);
        chk("arb_wr_err", 64'(wr_err_cnt), 64'(sat(wr_tot)));
        aw_dly = 0; w_dly = 0;

        // Counter saturation on both paths
        bn0 = b_n; wn0 = w_n;
        for (int j = 0; j < 9; j++) bplan[b_idx + j] = RESP_SLVERR;
        bplan[b_idx + 9] = RESP_OKAY;
        wr_tot += 9;
        send_byte(8'h5A, acc);
        wait_bn(bn0 + 10);
        chk("sat_write_count", 64'(w_n - wn0), 64'd10);
        chk("sat_wr_err", 64'(wr_err_cnt), 64'(sat(wr_tot)));
        rn = r_idx;
        for (int j = 0; j < 9; j++) rplan[rn + j] = RESP_DECERR;
        rd_tot += 9;
        wait_ridx(rn + 9);
        chk("sat_rd_err", 64'(rd_err_cnt), 64'(sat(rd_tot)));

        // Reset in the middle of a write
        aw_dly = 20; w_dly = 20;
        send_byte(8'($urandom), acc);
        repeat (2) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        chk("rst_mid_valids", {58'd0, awvalid, wvalid, arvalid, bready, rready, m_rx_valid}, 64'd0);
        chk("rst_mid_cnt", 64'({wr_err_cnt, rd_err_cnt}), 64'd0);
        wn0 = w_n; bn0 = b_n;
        @(negedge clk); nrst = 1'b1;
        aw_dly = 0; w_dly = 0;
        y = 8'($urandom);
        send_byte(y, acc);
        wait_bn(bn0 + 1);
        chk("rst_fresh_count", 64'(w_n - wn0), 64'd1);
        chk("rst_fresh_data", 64'(w_log[wn0]), 64'(y));
        chk("rst_fresh_addr", 64'(aw_log[aw_n - 1]), 64'(TXA));

        repeat (5) @(negedge clk);
        chk("protocol_violations", 64'(viol), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
